// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC, registers ALU status flags and
// redirects fetch on taken jumps/branches with a one-cycle squash bubble.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter int                  DATA_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  input  logic                  ALU_WE,
  output logic                  ZERO,
  output logic                  SIGN,
  input  logic                  JUMP_BRANCH_FLAG,
  input  logic [PC_WIDTH-1:0]   BRANCH_TARGET,
  input  logic                  STALL,
  output logic [PC_WIDTH-1:0]   PC,
  output logic                  FETCH_VALID,
  output logic                  FLUSH,
  output logic [7:0]            BRANCH_COUNT
);

  // Bit 0 of the encoding is set only in RUN, so FETCH_VALID is a plain flop output.
  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  state_t              state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                flush_reg, flush_next;
  logic [7:0]          count_reg, count_next;
  logic                zero_reg, sign_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
      flush_reg <= 1'b0;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flush_reg <= flush_next;
      count_reg <= count_next;
    end
  end

  // Flags track ALU write-back independently of stalls and sequencing state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      zero_reg <= 1'b0;
      sign_reg <= 1'b0;
    end else if (ALU_WE) begin
      zero_reg <= (ALU_RESULT == '0);
      sign_reg <= ALU_RESULT[DATA_WIDTH-1];
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flush_next = 1'b0;
    count_next = count_reg;
    if (!STALL) begin
      case (state_reg)
        BOOT: begin
          state_next = RUN;
        end
        RUN: begin
          if (JUMP_BRANCH_FLAG) begin
            pc_next    = BRANCH_TARGET;
            flush_next = 1'b1;
            state_next = REDIRECT;
            if (count_reg != 8'hFF) begin
              count_next = count_reg + 8'd1;
            end
          end else begin
            pc_next = pc_reg + PC_WIDTH'(1);
          end
        end
        REDIRECT: begin
          state_next = RUN;
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

  assign PC           = pc_reg;
  assign FETCH_VALID  = state_reg[0];
  assign FLUSH        = flush_reg;
  assign BRANCH_COUNT = count_reg;
  assign ZERO         = zero_reg;
  assign SIGN         = sign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] ALU_RESULT;
  logic       ALU_WE;
  logic       ZERO;
  logic       SIGN;
  logic       JUMP_BRANCH_FLAG;
  logic [7:0] BRANCH_TARGET;
  logic       STALL;
  logic [7:0] PC;
  logic       FETCH_VALID;
  logic       FLUSH;
  logic [7:0] BRANCH_COUNT;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_sequencer #(
    .PC_WIDTH    (8),
    .DATA_WIDTH  (8),
    .RESET_VECTOR(8'h10)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .ALU_RESULT      (ALU_RESULT),
    .ALU_WE          (ALU_WE),
    .ZERO            (ZERO),
    .SIGN            (SIGN),
    .JUMP_BRANCH_FLAG(JUMP_BRANCH_FLAG),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .STALL           (STALL),
    .PC              (PC),
    .FETCH_VALID     (FETCH_VALID),
    .FLUSH           (FLUSH),
    .BRANCH_COUNT    (BRANCH_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling/driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [7:0] pc, input logic fv, input logic fl);
    check_eq({tag, "_pc"}, 32'(PC), 32'(pc));
    check_eq({tag, "_fv"}, 32'(FETCH_VALID), 32'(fv));
    check_eq({tag, "_flush"}, 32'(FLUSH), 32'(fl));
    $display("[TB] %s: PC=%02h FV=%0b FLUSH=%0b BC=%0d Z=%0b S=%0b",
             tag, PC, FETCH_VALID, FLUSH, BRANCH_COUNT, ZERO, SIGN);
  endtask

  int exp_count;

  initial begin
    RST = 1'b1; ALU_RESULT = 8'h00; ALU_WE = 1'b0;
    JUMP_BRANCH_FLAG = 1'b0; BRANCH_TARGET = 8'h00; STALL = 1'b0;

    // Reset and free-run
    step();
    check_pc("reset", 8'h10, 1'b0, 1'b0);
    check_eq("reset_bc", 32'(BRANCH_COUNT), 32'd0);
    check_eq("reset_zero", 32'(ZERO), 32'd0);
    check_eq("reset_sign", 32'(SIGN), 32'd0);
    RST = 1'b0;
    step(); check_pc("boot_exit", 8'h10, 1'b1, 1'b0);
    step(); check_pc("run1", 8'h11, 1'b1, 1'b0);
    step(); check_pc("run2", 8'h12, 1'b1, 1'b0);

    // Taken branch at 0x12 -> 0x40, flag held through REDIRECT
    JUMP_BRANCH_FLAG = 1'b1; BRANCH_TARGET = 8'h40;
    step(); check_pc("br_take", 8'h40, 1'b0, 1'b1);
    check_eq("br_count1", 32'(BRANCH_COUNT), 32'd1);
    BRANCH_TARGET = 8'h80;
    step(); check_pc("br_redirect", 8'h40, 1'b1, 1'b0);
    check_eq("br_count_hold", 32'(BRANCH_COUNT), 32'd1);
    JUMP_BRANCH_FLAG = 1'b0;
    step(); check_pc("br_next", 8'h41, 1'b1, 1'b0);

    // Flags
    ALU_WE = 1'b1; ALU_RESULT = 8'h00;
    step(); check_eq("flag0_zero", 32'(ZERO), 32'd1); check_eq("flag0_sign", 32'(SIGN), 32'd0);
    ALU_RESULT = 8'h80;
    step(); check_eq("flag80_zero", 32'(ZERO), 32'd0); check_eq("flag80_sign", 32'(SIGN), 32'd1);
    ALU_WE = 1'b0; ALU_RESULT = 8'h05;
    step(); check_eq("flagnowe_zero", 32'(ZERO), 32'd0); check_eq("flagnowe_sign", 32'(SIGN), 32'd1);
    check_pc("flags_pc", 8'h44, 1'b1, 1'b0);

    // Stall with pending branch; ALU write lands during the stall
    STALL = 1'b1; JUMP_BRANCH_FLAG = 1'b1; BRANCH_TARGET = 8'h20;
    step(); check_pc("stall1", 8'h44, 1'b1, 1'b0);
    ALU_WE = 1'b1; ALU_RESULT = 8'h00;
    step(); check_pc("stall2", 8'h44, 1'b1, 1'b0);
    check_eq("stall_zero", 32'(ZERO), 32'd1); check_eq("stall_sign", 32'(SIGN), 32'd0);
    ALU_WE = 1'b0;
    step(); check_pc("stall3", 8'h44, 1'b1, 1'b0);
    check_eq("stall_bc", 32'(BRANCH_COUNT), 32'd1);
    STALL = 1'b0;
    step(); check_pc("unstall_br", 8'h20, 1'b0, 1'b1);
    check_eq("unstall_bc", 32'(BRANCH_COUNT), 32'd2);
    JUMP_BRANCH_FLAG = 1'b0;
    step(); check_pc("unstall_redir", 8'h20, 1'b1, 1'b0);
    step(); check_pc("unstall_next", 8'h21, 1'b1, 1'b0);

    // Same-cycle ALU write and branch, then wrap at 0xFF
    ALU_WE = 1'b1; ALU_RESULT = 8'h01;
    step(); check_eq("pre_zero", 32'(ZERO), 32'd0);
    ALU_RESULT = 8'h00; JUMP_BRANCH_FLAG = 1'b1; BRANCH_TARGET = 8'hFE;
    step(); check_pc("simul_br", 8'hFE, 1'b0, 1'b1);
    check_eq("simul_zero", 32'(ZERO), 32'd1);
    check_eq("simul_bc", 32'(BRANCH_COUNT), 32'd3);
    ALU_WE = 1'b0; JUMP_BRANCH_FLAG = 1'b0;
    step(); check_pc("wrap0", 8'hFE, 1'b1, 1'b0);
    step(); check_pc("wrap1", 8'hFF, 1'b1, 1'b0);
    step(); check_pc("wrap2", 8'h00, 1'b1, 1'b0);
    step(); check_pc("wrap3", 8'h01, 1'b1, 1'b0);

    // Saturation: 260 more taken branches
    exp_count = 3;
    BRANCH_TARGET = 8'h30;
    for (int i = 0; i < 260; i++) begin
      JUMP_BRANCH_FLAG = 1'b1;
      step();
      if (exp_count < 255) exp_count++;
      check_eq("sat_bc", 32'(BRANCH_COUNT), 32'(exp_count));
      JUMP_BRANCH_FLAG = 1'b0;
      step();
    end
    check_eq("sat_final", 32'(BRANCH_COUNT), 32'd255);

    // Reset in the cycle after a branch
    JUMP_BRANCH_FLAG = 1'b1; BRANCH_TARGET = 8'h55;
    step(); check_pc("last_br", 8'h55, 1'b0, 1'b1);
    RST = 1'b1; JUMP_BRANCH_FLAG = 1'b0;
    step(); check_pc("rst_mid", 8'h10, 1'b0, 1'b0);
    check_eq("rst_mid_bc", 32'(BRANCH_COUNT), 32'd0);
    check_eq("rst_mid_zero", 32'(ZERO), 32'd0);
    check_eq("rst_mid_sign", 32'(SIGN), 32'd0);
    RST = 1'b0;
    step(); check_pc("rst_boot_exit", 8'h10, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the fetch/branch path. It holds the PC and registers the ZERO/SIGN status flags from ALU results. It drives those flags to the jump/branch unit and consumes that unit's JUMP_BRANCH_FLAG to redirect fetch, inserting a one-cycle squash bubble on every taken jump or branch. It sits between the ALU write-back, the jump/branch unit and instruction memory.

## Interface
- PC_WIDTH, 8, PC and BRANCH_TARGET width
- DATA_WIDTH, 8, ALU_RESULT width
- RESET_VECTOR, 0, PC value loaded on reset
- CLK  input  1  single clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- ALU_RESULT  input  DATA_WIDTH  result of the ALU op completing this cycle
- ALU_WE  input  1  flag-update enable; 1 = latch flags from ALU_RESULT
- ZERO  output  1  registered flag: last latched ALU_RESULT == 0
- SIGN  output  1  registered flag: last latched ALU_RESULT[DATA_WIDTH-1]
- JUMP_BRANCH_FLAG  input  1  taken indication from jump/branch unit (computed from ZERO/SIGN above)
- BRANCH_TARGET  input  PC_WIDTH  redirect address, valid with JUMP_BRANCH_FLAG
- STALL  input  1  downstream hold; freezes PC/state
- PC  output  PC_WIDTH  current fetch address
- FETCH_VALID  output  1  PC is a live fetch (0 in BOOT and REDIRECT)
- FLUSH  output  1  one-cycle pulse: squash instruction in flight
- BRANCH_COUNT  output  8  taken-redirect counter, saturates at 255

## Operation
- FSM states: BOOT, RUN, REDIRECT.
  - BOOT -> RUN after one non-stalled cycle.
  - RUN -> REDIRECT on a taken branch.
  - REDIRECT -> RUN after one non-stalled cycle.
- The FSM and PC update with this priority: RST > STALL > taken branch > increment.
- RUN, STALL=0, JUMP_BRANCH_FLAG=1:
  - PC <= BRANCH_TARGET.
  - FLUSH <= 1.
  - BRANCH_COUNT increments, holding at 255.
  - State <= REDIRECT.
- RUN, STALL=0, JUMP_BRANCH_FLAG=0: PC <= PC+1, modulo 2^PC_WIDTH (0xFF wraps to 0x00).
- REDIRECT: JUMP_BRANCH_FLAG is ignored (the shadow instruction is squashed); PC holds the target.
- BOOT: JUMP_BRANCH_FLAG is ignored; PC holds RESET_VECTOR.
- STALL=1: PC, state and BRANCH_COUNT hold; FLUSH <= 0; JUMP_BRANCH_FLAG is ignored. Upstream holds the branch stable until the stall releases.
- Flags: when ALU_WE=1, ZERO <= (ALU_RESULT==0) and SIGN <= ALU_RESULT[MSB]. Flags update regardless of STALL and FSM state.
- Same-cycle ALU_WE and JUMP_BRANCH_FLAG: the branch decision uses the pre-edge flag values; the new flags become visible the next cycle. There is no bypass.

## Timing
- Reset values, in the cycle after the RST edge: PC=RESET_VECTOR, ZERO=0, SIGN=0, FETCH_VALID=0, FLUSH=0, BRANCH_COUNT=0, state=BOOT.
- RST asserted mid-operation (including during REDIRECT or STALL) overrides everything at that edge.
- FETCH_VALID=1 exactly when state=RUN. It is combinational from the state register and glitch-free.
- Taken-branch latency:
  - Decision at edge N.
  - PC=target from N+1, with FLUSH=1 and FETCH_VALID=0.
  - Fetch of the target is valid from N+2.
  - Target+1 at N+3 if no stall.
- FLUSH lasts exactly one cycle per taken branch and is never asserted during STALL.
- Flag latency: one cycle from ALU_WE to ZERO/SIGN.

## Test plan
- Reset then free-run, RESET_VECTOR=0x10:
  - PC=0x10 with FETCH_VALID=0 for one cycle.
  - Then PC=0x10 with FETCH_VALID=1, followed by 0x11, 0x12, ...
  - Preset PC near 0xFF: 0xFF -> 0x00 wrap.
- Flags:
  - ALU_RESULT=0x00, ALU_WE=1 -> ZERO=1, SIGN=0 next cycle.
  - 0x80 -> ZERO=0, SIGN=1.
  - 0x05 with ALU_WE=0 -> flags unchanged.
- Taken branch at PC=0x12, BRANCH_TARGET=0x40:
  - Next cycle PC=0x40, FLUSH=1, FETCH_VALID=0, BRANCH_COUNT=1.
  - Then PC=0x40 with FETCH_VALID=1, then 0x41.
  - JUMP_BRANCH_FLAG=1 held during REDIRECT causes no second redirect.
- STALL:
  - STALL=1 for 3 cycles with JUMP_BRANCH_FLAG=1 -> PC frozen, no FLUSH.
  - Release STALL -> redirect occurs.
  - ALU_WE during the stall still updates ZERO/SIGN.
- Simultaneous ALU_WE (result 0x00) and a taken branch (flags previously ZERO=0): branch taken per the JUMP_BRANCH_FLAG input; ZERO=1 the following cycle.
- 260 taken branches -> BRANCH_COUNT saturates at 255. RST in the cycle after a branch -> all outputs return to reset values.
